// File: rtl/count_req_pkg.sv
// rtl/count_req_pkg.sv - shared state encoding and default constants for count_requester
package count_req_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_W   = 8;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/count_req_timer.sv
// rtl/count_req_timer.sv - loadable down-counter with zero flag, shared by gap and watchdog timing
module count_req_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // load wins over dec; the count holds at zero instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/count_requester.sv
// rtl/count_requester.sv - batch initiator driving counting and consuming ready completions
// Optional watchdog on the REQ wait is enabled by defining COUNT_REQ_TIMEOUT_EN.
module count_requester
  import count_req_pkg::*;
#(
  parameter int NUM_W   = DEF_NUM_W,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num_jobs,
  input  logic             ready,
  output logic             counting,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] jobs_done,
  output logic             timeout_err
);

  localparam int TMAX = max2(GAP, TIMEOUT);
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP - 1);
`ifdef COUNT_REQ_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
`endif

  state_t           state_q, state_d;
  logic [NUM_W-1:0] target_q;
  logic [NUM_W-1:0] jobs_done_q;
  logic [NUM_W-1:0] jobs_next;
  logic             ready_q;
  logic             ready_rise;
  logic             accept;
  logic             jobs_inc;
  logic             tmr_load;
  logic [TW-1:0]    tmr_value;
  logic             tmr_dec;
  logic             tmr_zero;
`ifdef COUNT_REQ_TIMEOUT_EN
  logic             abort;
  logic             timeout_err_q;
`endif

  assign ready_rise = ready & ~ready_q;
  assign jobs_next  = jobs_done_q + NUM_W'(1);

  count_req_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    jobs_inc  = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = GAP_LOAD;
    tmr_dec   = 1'b0;
`ifdef COUNT_REQ_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_jobs == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
`ifdef COUNT_REQ_TIMEOUT_EN
            tmr_load  = 1'b1;
            tmr_value = TO_LOAD;
`endif
          end
        end
      end
      S_REQ: begin
        // a completion in the watchdog's last cycle still counts as success
        if (ready_rise) begin
          jobs_inc = 1'b1;
          if (jobs_next == target_q) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_GAP;
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
          end
        end
`ifdef COUNT_REQ_TIMEOUT_EN
        else if (tmr_zero) begin
          abort   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (tmr_zero) begin
          state_d = S_REQ;
`ifdef COUNT_REQ_TIMEOUT_EN
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      target_q    <= '0;
      jobs_done_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready;
      if (accept) begin
        target_q    <= num_jobs;
        jobs_done_q <= '0;
      end else if (jobs_inc) begin
        jobs_done_q <= jobs_next;
      end
    end
  end

`ifdef COUNT_REQ_TIMEOUT_EN
  // sticky until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else if (accept) begin
      timeout_err_q <= 1'b0;
    end else if (abort) begin
      timeout_err_q <= 1'b1;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign counting  = (state_q == S_REQ);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign jobs_done = jobs_done_q;

endmodule

// File: doc/count_requester.md
Name: count_requester

Overview:
- Initiator side of the counting/ready handshake: drives `counting` into the counting controller and consumes its `ready` completion indication.
- Runs a batch of N count jobs per `start` request, with a programmable idle gap between jobs.
- Reports progress, a one-cycle completion pulse, and optionally a watchdog error.
- Sits between the top-level sequencer and the counting controller.

Parameters:
- NUM_W, 8, width of job-count input and progress counter.
- GAP, 2, idle cycles with counting=0 between consecutive jobs (≥1).
- TIMEOUT, 64, max cycles in REQ without ready before abort (watchdog build only, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a batch; sampled only in IDLE.
- num_jobs  in  NUM_W  jobs in batch; latched when start is accepted.
- ready  in  1  completion indication from counting controller.
- counting  out  1  job request to counting controller.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at batch end (normal or aborted).
- jobs_done  out  NUM_W  jobs completed in current/last batch.
- timeout_err  out  1  sticky watchdog abort flag.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; counting=0, busy=0, done=0, jobs_done=0, timeout_err=0; ready_q=0; timer cleared. Reset mid-batch drops counting immediately, without waiting for clk.
- Completion event: ready_rise = ready & ~ready_q; ready_q is registered every cycle in all states. A held-high ready counts once.
- States: IDLE, REQ, GAP, DONE. Encoding is 2-bit binary, registered; counting is decoded from state (counting=1 iff state==REQ).
- IDLE: on start=1, latch num_jobs into target, clear jobs_done, clear timeout_err.
  - target==0 → DONE.
  - Otherwise → REQ. counting is high from the cycle after the start edge.
- REQ: on ready_rise, jobs_done += 1 at the same edge.
  - If jobs_done+1 == target → DONE.
  - Otherwise → GAP, loading timer=GAP-1. counting=0 from the next cycle.
- GAP: timer decrements each cycle. At timer==0 → REQ. Exactly GAP cycles of counting=0.
- DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored: no latch, no effect.
- ready_rise outside REQ is ignored; jobs_done is unchanged.
- jobs_done arithmetic: NUM_W-bit unsigned. It cannot wrap, because it stops at target ≤ 2^NUM_W-1.
- busy = (state != IDLE). busy stays high during DONE.
- start and ready_rise in the same IDLE cycle: start is accepted; ready_rise is ignored.

Optional Feature:
- Macro COUNT_REQ_TIMEOUT_EN.
- Defined:
  - Entering REQ loads timer=TIMEOUT-1; the timer decrements each REQ cycle without ready_rise.
  - Timer reaching 0 with no ready_rise in that cycle → counting=0, timeout_err=1 (sticky until next accepted start or reset), → DONE. jobs_done keeps its value.
  - ready_rise in the same cycle the timer reaches 0 counts as success.
- Undefined: REQ waits indefinitely; timeout_err is tied to 0; the timer is used for GAP only.

Decomposition:
- Package count_req_pkg: state localparams (S_IDLE=0, S_REQ=1, S_GAP=2, S_DONE=3) and the default constants for NUM_W/GAP/TIMEOUT.
- Sub-module count_req_timer: loadable down-counter with load, value, and zero flag. Shared by the GAP and watchdog functions; width is $clog2(max(GAP,TIMEOUT)).

Test Plan:
- Reset then start, num_jobs=3, GAP=2; model raises ready 5 cycles after each counting rise → three counting pulses separated by exactly 2 low cycles; jobs_done 1→2→3; single done pulse; busy falls the cycle after done.
- start with num_jobs=0 → no counting; done=1 exactly one cycle after start; jobs_done=0.
- ready held high for 10 cycles during REQ, num_jobs=2 → jobs_done increments once per rising edge only; second job waits for ready to fall and rise again.
- start pulsed in REQ and GAP during a 2-job batch → ignored; batch still ends with jobs_done=2; extra ready pulses in GAP/IDLE do not change jobs_done.
- rst_n driven low between clock edges mid-REQ → counting=0 and all outputs zero before the next clk edge; a new start after release runs normally.
- COUNT_REQ_TIMEOUT_EN defined, TIMEOUT=8, ready never asserted → counting high 8 cycles then low; timeout_err=1; done pulse; jobs_done=0; next start clears timeout_err.
